// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Brief    : Shared state encoding and default sizing for the memory access
//            controller and its wait timer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    localparam int c_DATA_W      = 32;
    localparam int c_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : BUSY-cycle counter; flags expiry on the TIMEOUT_CYC-th BUSY cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_busy,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYC);

    logic [c_CNT_W-1:0] r_count;

    // Loaded with 1 so the first BUSY cycle already reads as cycle one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= c_CNT_W'(1);
        end else if (i_busy && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign o_expired = i_busy && (r_count == c_LIMIT);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Load/store sequencer between pipeline and data memory
//            (IDLE -> BUSY -> DONE). Optional macro MEM_TIMEOUT_EN adds a
//            BUSY-cycle abort with an err_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-3:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_access;
    logic              w_timeout;
    logic              w_unused_byte_sel;

    assign w_access          = MemRead_i | MemWrite_i;
    assign w_unused_byte_sel = ^addr_i[1:0];

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   ((r_state == IDLE) && w_access),
        .i_busy    (r_state == BUSY),
        .o_expired (w_timeout)
    );

    // Set on the abort transition so the pulse coincides with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == BUSY) && !mem_ready_i && w_timeout;
        end
    end

    assign err_o = r_err;
`else
    localparam int c_unused_timeout = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_state <= BUSY;
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= addr_i[DATA_W-1:2];
                        r_wdata <= wdata_i;
                    end
                end
                BUSY: begin
                    // A real completion takes precedence over an expiring timer.
                    if (mem_ready_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o     = (r_state == BUSY) || ((r_state == IDLE) && w_access);
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl against a transaction-level
//            model (stall length, latched request, load result, timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int c_TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W      (32),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the following IDLE cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rmem, input int waits);
        bit we;
        bit tmo;
        int busy_len;
        int stalls;
        we     = wr;
        stalls = 0;
`ifdef MEM_TIMEOUT_EN
        tmo      = (waits >= c_TMO);
        busy_len = tmo ? c_TMO : waits + 1;
`else
        tmo      = 1'b0;
        busy_len = waits + 1;
`endif
        MemRead_i   = rd;
        MemWrite_i  = wr;
        addr_i      = addr;
        wdata_i     = wd;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1;
        check("idle_req", {63'd0, mem_req_o}, 64'd0);
        stalls += int'(stall_o);
        for (int k = 0; k < busy_len; k++) begin
            step();
            check("busy_req", {63'd0, mem_req_o}, 64'd1);
            check("busy_we", {63'd0, mem_we_o}, {63'd0, we});
            check("busy_addr", {34'd0, mem_addr_o}, {34'd0, addr[31:2]});
            if (we) check("busy_wdata", {32'd0, mem_wdata_o}, {32'd0, wd});
            check("busy_rdata_hold", {32'd0, rdata_o}, {32'd0, m_rdata});
            stalls += int'(stall_o);
            MemRead_i   = 1'($urandom_range(0, 1));
            MemWrite_i  = 1'($urandom_range(0, 1));
            addr_i      = $urandom;
            wdata_i     = $urandom;
            mem_ready_i = !tmo && (k == waits);
            mem_rdata_i = mem_ready_i ? rmem : $urandom;
        end
        step();
        if (!we) m_rdata = tmo ? 32'd0 : rmem;
        check("done_req", {63'd0, mem_req_o}, 64'd0);
        check("done_stall", {63'd0, stall_o}, 64'd0);
        check("done_rdata", {32'd0, rdata_o}, {32'd0, m_rdata});
        check("done_err", {63'd0, err_o}, {63'd0, tmo});
        check("stall_cycles", 64'(stalls), tmo ? 64'(c_TMO + 1) : 64'(waits + 2));
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        step();
        check("after_done_req", {63'd0, mem_req_o}, 64'd0);
        check("after_done_err", {63'd0, err_o}, 64'd0);
        check("after_done_rdata", {32'd0, rdata_o}, {32'd0, m_rdata});
    endtask

    task automatic go_idle();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        go_idle();
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
        m_rdata     = '0;
        step();
        step();
        check("rst_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_addr", {34'd0, mem_addr_o}, 64'd0);
        check("rst_rdata", {32'd0, rdata_o}, 64'd0);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        rst_n = 1'b1;
        step();

        run_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 1'b1, $urandom, 32'h1234_5678, $urandom, 3);
        run_txn(1'b1, 1'b1, $urandom, $urandom, $urandom, 1);
        run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 0);
        run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 2);
`ifdef MEM_TIMEOUT_EN
        run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 1000);
        run_txn(1'b0, 1'b1, $urandom, $urandom, $urandom, 1000);
`else
        run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 10);
`endif
        for (int n = 0; n < 40; n++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(0, 6)));
        end

        // Reset in the 2nd BUSY cycle with a completion pending.
        go_idle();
        step();
        MemRead_i = 1'b1;
        addr_i    = $urandom;
        step();
        step();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hA5A5_5A5A;
        rst_n       = 1'b0;
        m_rdata     = '0;
        #1;
        check("arst_req", {63'd0, mem_req_o}, 64'd0);
        check("arst_rdata", {32'd0, rdata_o}, 64'd0);
        check("arst_addr", {34'd0, mem_addr_o}, 64'd0);
        check("arst_stall_idle", {63'd0, stall_o}, 64'd1);
        MemRead_i = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_req", {63'd0, mem_req_o}, 64'd0);
            check("post_rst_stall", {63'd0, stall_o}, 64'd0);
            check("post_rst_rdata", {32'd0, rdata_o}, 64'd0);
            check("post_rst_err", {63'd0, err_o}, 64'd0);
        end
        run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 1);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_access_ctrl
`default_nettype wire
